demux4_deser: RTL
=================

DEMUX4_DESER -- requirements
Module: demux4_deser

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port din, input, 1, shared serial data line sampled from the 4-to-1 mux output.
REQ-004 SHALL have port din_valid, input, 1, qualifies din for the current cycle.
REQ-005 SHALL have ports s1, s0, input, 1 each, channel select; channel index = {s1,s0}, 0..3.
REQ-006 SHALL have port flush, input, 1, discards all partially assembled frames.
REQ-007 SHALL have ports d0, d1, d2, d3, output, 8 each, last completed byte per channel.
REQ-008 SHALL have ports v0, v1, v2, v3, output, 1 each, one-cycle completion pulse per channel.
REQ-009 SHALL have ports pe0, pe1, pe2, pe3, output, 1 each, parity error flag per channel.

Function
REQ-010 SHALL keep, per channel, an independent 8-bit shift register and bit counter.
REQ-011 SHALL, on a rising edge with din_valid=1 and flush=0, shift din into the selected channel only, LSB first, and increment that channel's counter.
REQ-012 SHALL leave the counters and shift registers of unselected channels unchanged.
REQ-013 SHALL, on the edge sampling the last bit of a frame, load the assembled byte into dN, pulse vN high for exactly the following cycle, and reset that counter to 0.
REQ-014 SHALL have a latency of one cycle from the last-bit edge to dN/vN visibility, with no bubble, so back-to-back frames on one channel are accepted.
REQ-015 SHALL hold dN and peN stable between completions of channel N.
REQ-016 SHALL ignore din when din_valid=0, with no state change.
REQ-017 SHALL, when flush=1, clear all counters and shift registers on that edge, leave dN and peN untouched, and drop any bit presented that cycle even with din_valid=1.
REQ-018 SHALL allow a select change on any cycle; interleaved bits resume each channel's partial frame where it stopped.
REQ-019 SHALL treat counter wrap as frame completion only; no overflow state exists.

Reset
REQ-020 SHALL, while rst=1 at a rising edge, clear all counters, shift registers, d0..d3 to 8'h00, v0..v3 to 0 and pe0..pe3 to 0.
REQ-021 SHALL give rst priority over flush and din_valid.
REQ-022 SHALL discard any frame in progress when rst asserts mid-frame; the first valid bit after reset is bit 0.

Configuration
REQ-023 SHALL use macro DEMUX4_PARITY_EN to select the parity feature.
REQ-024 SHALL, with DEMUX4_PARITY_EN defined, use 9-bit frames: 8 data bits LSB first, then one even-parity bit.
REQ-025 SHALL, with parity enabled, set peN at completion to (XOR of the 8 data bits) XOR (parity bit), and still load dN and pulse vN.
REQ-026 SHALL, without DEMUX4_PARITY_EN, use 8-bit frames and tie pe0..pe3 to 0; ports remain present in both builds.

Verification
REQ-027 SHALL cover this directed test: reset, sel=2, send 8'hA5 LSB first on 8 consecutive valid cycles -> d2=8'hA5, v2 pulses exactly one cycle after the 8th bit, v0/v1/v3 stay 0.
REQ-028 SHALL cover this directed test: interleave 8'h3C on channel 0 and 8'hC3 on channel 3 bit by bit -> d0=8'h3C, d3=8'hC3, each v pulses once.
REQ-029 SHALL cover this directed test: 4 valid bits to channel 1, then flush, then 8'hFF -> d1=8'hFF with no corruption; d1 is unchanged at the flush edge.
REQ-030 SHALL cover this directed test: rst pulse after 5 bits on channel 0, then 8'h81 -> d0=8'h81, and all outputs were 0 during reset.
REQ-031 SHALL cover this directed test, DEMUX4_PARITY_EN defined: 8'h07 with parity bit 1 -> pe=0; same byte with parity bit 0 -> pe=1, d=8'h07 both times.
REQ-032 SHALL cover this directed test: din_valid gaps of 1-3 cycles between bits of 8'h5A on channel 2 -> d2=8'h5A, single v2 pulse.

Source files
------------

// File: rtl/demux4_deser.sv
// Four-channel serial deserializer fed by a shared 4:1 muxed data line.
// Define DEMUX4_PARITY_EN to use 9-bit frames (8 data bits LSB first plus even parity).
module demux4_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       s1,
  input  logic       s0,
  input  logic       flush,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic       v0,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  output logic       pe0,
  output logic       pe1,
  output logic       pe2,
  output logic       pe3
);

`ifdef DEMUX4_PARITY_EN
  localparam int unsigned FRAME_BITS = 9;
`else
  localparam int unsigned FRAME_BITS = 8;
`endif
  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic [7:0]       r_sr  [NCH];
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [7:0]       r_d   [NCH];
  logic [NCH-1:0]   r_v;
`ifdef DEMUX4_PARITY_EN
  logic [NCH-1:0]   r_pe;
`endif
  logic [1:0]       w_sel;

  assign w_sel = {s1, s0};

  // Per-channel assembly; only the selected channel moves on a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_sr[i]  <= '0;
        r_cnt[i] <= '0;
        r_d[i]   <= '0;
      end
      r_v <= '0;
`ifdef DEMUX4_PARITY_EN
      r_pe <= '0;
`endif
    end else begin
      r_v <= '0;
      if (flush) begin
        for (int i = 0; i < NCH; i++) begin
          r_sr[i]  <= '0;
          r_cnt[i] <= '0;
        end
      end else if (din_valid) begin
        if (r_cnt[w_sel] == LAST_BIT) begin
          r_cnt[w_sel] <= '0;
          r_sr[w_sel]  <= '0;
          r_v[w_sel]   <= 1'b1;
`ifdef DEMUX4_PARITY_EN
          // Final bit is the parity bit; the byte is already fully shifted in.
          r_d[w_sel]  <= r_sr[w_sel];
          r_pe[w_sel] <= (^r_sr[w_sel]) ^ din;
`else
          r_d[w_sel]  <= {din, r_sr[w_sel][7:1]};
`endif
        end else begin
          r_cnt[w_sel] <= r_cnt[w_sel] + CNT_W'(1);
          r_sr[w_sel]  <= {din, r_sr[w_sel][7:1]};
        end
      end
    end
  end

  assign d0 = r_d[0];
  assign d1 = r_d[1];
  assign d2 = r_d[2];
  assign d3 = r_d[3];
  assign v0 = r_v[0];
  assign v1 = r_v[1];
  assign v2 = r_v[2];
  assign v3 = r_v[3];

`ifdef DEMUX4_PARITY_EN
  assign pe0 = r_pe[0];
  assign pe1 = r_pe[1];
  assign pe2 = r_pe[2];
  assign pe3 = r_pe[3];
`else
  assign pe0 = 1'b0;
  assign pe1 = 1'b0;
  assign pe2 = 1'b0;
  assign pe3 = 1'b0;
`endif

endmodule
